// File: rtl/axi_vram_pkg.sv
// ---------------------------------------------------------------------------
// axi_vram_pkg
// Shared types and constants for the AXI4 read-only VRAM slave.
//   rd_state_t     : read FSM states (IDLE -> FETCH -> SEND)
//   RESP_*         : RRESP encodings
//   BURST_*        : ARBURST encodings
//   SIZE_4B        : the only beat size served (32-bit words)
//   burstIsLegal() : true when the burst type and beat size can be served
// ---------------------------------------------------------------------------
package axi_vram_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, SEND} rd_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [2:0] SIZE_4B = 3'b010;

   // WRAP and the reserved encoding 2'b11 are refused for the whole burst,
   // as is any beat size other than one 32-bit word.
   function automatic logic burstIsLegal(input logic [1:0] burst, input logic [2:0] size);
      return (size == SIZE_4B) && (burst != BURST_WRAP) && (burst != 2'b11);
   endfunction

endpackage

// File: rtl/axi_vram_rd_slave_vram_sp_ram.sv
// ---------------------------------------------------------------------------
// vram_sp_ram
// Read-first synchronous RAM: one write port (backdoor preload) and one
// read port (read FSM), written so it maps onto block RAM.
// Ports:
//   clock, reset       : clock and synchronous active-high reset (output reg only)
//   writeEn/Addr/Data  : backdoor write, out-of-range addresses are dropped
//   readEn/readAddr    : read request, data appears one clock later
//   readData           : registered read data, holds while readEn is low
// ---------------------------------------------------------------------------
module vram_sp_ram #(
   parameter int WORDS  = 307200,
   parameter int DATA_W = 32,
   parameter int AW     = $clog2(WORDS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              writeEn,
   input  logic [AW-1:0]     writeAddr,
   input  logic [DATA_W-1:0] writeData,
   input  logic              readEn,
   input  logic [AW-1:0]     readAddr,
   output logic [DATA_W-1:0] readData
);

   logic [DATA_W-1:0] mem [0:WORDS-1];

   // Backdoor write port. The address field is wider than the array when
   // WORDS is not a power of two, so indices past the end are ignored here.
   always_ff @(posedge clock) begin
      if (writeEn && (int'(writeAddr) < WORDS)) begin
         mem[writeAddr] <= writeData;
      end
   end

   // Read port. Kept in its own block with non-blocking assignment so a
   // same-cycle write to the same word returns the old contents. The output
   // register is cleared on reset; the array itself is never cleared.
   always_ff @(posedge clock) begin
      if (reset) begin
         readData <= '0;
      end else if (readEn) begin
         readData <= mem[readAddr];
      end
   end

endmodule

// File: rtl/axi_vram_rd_slave.sv
// ---------------------------------------------------------------------------
// axi_vram_rd_slave
// AXI4 read-only slave serving display VRAM reads from an internal word
// memory that is preloaded through a backdoor write port. One burst is
// outstanding at a time; each beat takes a FETCH cycle and a SEND cycle.
// Ports:
//   ACLK, ARESET                 : clock, synchronous active-high reset
//   AR* (ARID..ARVALID), ARREADY : read address channel
//   R* (RID..RVALID), RREADY     : read data channel
//   MEM_WE/MEM_WADDR/MEM_WDATA   : backdoor memory write
// Optional build macro:
//   AXI_VRAM_ARREADY_RANDOM_EN   : gate ARREADY with a 16-bit LFSR to stress
//                                  the master's ARVALID hold behaviour
// ---------------------------------------------------------------------------
module axi_vram_rd_slave
   import axi_vram_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                ID_W      = 1,
   parameter int                MEM_WORDS = 307200,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h2000_0000,
   parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic [ID_W-1:0]              ARID,
   input  logic [ADDR_W-1:0]            ARADDR,
   input  logic [7:0]                   ARLEN,
   input  logic [2:0]                   ARSIZE,
   input  logic [1:0]                   ARBURST,
   input  logic                         ARVALID,
   output logic                         ARREADY,
   output logic [ID_W-1:0]              RID,
   output logic [DATA_W-1:0]            RDATA,
   output logic [1:0]                   RRESP,
   output logic                         RLAST,
   output logic                         RVALID,
   input  logic                         RREADY,
   input  logic                         MEM_WE,
   input  logic [$clog2(MEM_WORDS)-1:0] MEM_WADDR,
   input  logic [DATA_W-1:0]            MEM_WDATA
);

   localparam int AW = $clog2(MEM_WORDS);

   rd_state_t         state;
   logic [ID_W-1:0]   idReg;
   logic [7:0]        lenReg;
   logic [7:0]        beatCnt;
   logic [1:0]        burstReg;
   logic              burstErr;
   logic [ADDR_W-1:0] wordIdx;
   logic              arreadyReg;
   logic              rvalidReg;
   logic              rlastReg;
   logic [1:0]        rrespReg;
   logic [ID_W-1:0]   ridReg;
   logic [DATA_W-1:0] ramQ;
   logic              readyNext;

   // Word index in modular ADDR_W arithmetic: an address below BASE_ADDR
   // wraps to a huge index and therefore falls out of range on its own.
   logic [ADDR_W-1:0] arOffset;
   logic [ADDR_W-1:0] arWordIdx;
   logic              wordInRange;
   logic              ramReadEn;

   assign arOffset    = ARADDR - BASE_ADDR;
   assign arWordIdx   = arOffset >> 2;
   assign wordInRange = wordIdx < ADDR_W'(MEM_WORDS);
   assign ramReadEn   = (state == FETCH) && wordInRange;

`ifdef AXI_VRAM_ARREADY_RANDOM_EN
   logic [15:0] lfsr;
   logic [15:0] lfsrNext;

   // Fibonacci LFSR, taps 16/14/13/11. ARREADY is registered from the next
   // LFSR value so that it lines up with the LFSR bit of the same cycle.
   assign lfsrNext  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign readyNext = lfsrNext[0];

   // The LFSR free-runs every cycle; it only ever gates ARREADY.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= lfsrNext;
      end
   end
`else
   assign readyNext = 1'b1;
`endif

   vram_sp_ram #(
      .WORDS  (MEM_WORDS),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_ram (
      .clock     (ACLK),
      .reset     (ARESET),
      .writeEn   (MEM_WE),
      .writeAddr (MEM_WADDR),
      .writeData (MEM_WDATA),
      .readEn    (ramReadEn),
      .readAddr  (wordIdx[AW-1:0]),
      .readData  (ramQ)
   );

   // Read FSM. IDLE accepts one address, FETCH reads the RAM and decides
   // the response for this beat, SEND holds the beat until RREADY. All
   // channel outputs are registers, so they stay stable while RREADY is low.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state      <= IDLE;
         arreadyReg <= 1'b0;
         rvalidReg  <= 1'b0;
         rlastReg   <= 1'b0;
         rrespReg   <= RESP_OKAY;
         ridReg     <= '0;
         idReg      <= '0;
         lenReg     <= '0;
         burstReg   <= BURST_FIXED;
         burstErr   <= 1'b0;
         wordIdx    <= '0;
         beatCnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ARVALID && arreadyReg) begin
                  idReg      <= ARID;
                  lenReg     <= ARLEN;
                  burstReg   <= ARBURST;
                  burstErr   <= !burstIsLegal(ARBURST, ARSIZE) || (ARADDR < BASE_ADDR);
                  wordIdx    <= arWordIdx;
                  beatCnt    <= '0;
                  arreadyReg <= 1'b0;
                  state      <= FETCH;
               end else begin
                  arreadyReg <= readyNext;
               end
            end
            FETCH: begin
               rvalidReg <= 1'b1;
               rrespReg  <= (burstErr || !wordInRange) ? RESP_SLVERR : RESP_OKAY;
               rlastReg  <= (beatCnt == lenReg);
               ridReg    <= idReg;
               state     <= SEND;
            end
            SEND: begin
               if (RREADY) begin
                  rvalidReg <= 1'b0;
                  if (rlastReg) begin
                     rlastReg   <= 1'b0;
                     arreadyReg <= readyNext;
                     state      <= IDLE;
                  end else begin
                     if (burstReg == BURST_INCR) begin
                        wordIdx <= wordIdx + ADDR_W'(1);
                     end
                     beatCnt <= beatCnt + 8'd1;
                     state   <= FETCH;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Error beats return zero data regardless of what the RAM register holds.
   assign RDATA   = (rrespReg == RESP_SLVERR) ? '0 : ramQ;
   assign ARREADY = arreadyReg;
   assign RVALID  = rvalidReg;
   assign RLAST   = rlastReg;
   assign RRESP   = rrespReg;
   assign RID     = ridReg;

endmodule

// File: tb/tb_axi_vram_rd_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_vram_rd_slave
// Self-checking bench for axi_vram_rd_slave. Expected beats come from a
// word-level model of the memory and the address/response rules.
// ---------------------------------------------------------------------------
module tb_axi_vram_rd_slave;
   import axi_vram_pkg::*;

   localparam int          ADDR_W    = 32;
   localparam int          DATA_W    = 32;
   localparam int          ID_W      = 1;
   localparam int          MEM_WORDS = 307200;
   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [31:0] BASE_ADDR = 32'h2000_0000;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic [ID_W-1:0]   ARID;
   logic [ADDR_W-1:0] ARADDR;
   logic [7:0]        ARLEN;
   logic [2:0]        ARSIZE;
   logic [1:0]        ARBURST;
   logic              ARVALID;
   logic              ARREADY;
   logic [ID_W-1:0]   RID;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              RVALID;
   logic              RREADY;
   logic              MEM_WE;
   logic [AW-1:0]     MEM_WADDR;
   logic [DATA_W-1:0] MEM_WDATA;

   int checks = 0;
   int errors = 0;

   // Behavioural picture of the VRAM contents, keyed by word index.
   logic [31:0] modelMem [int unsigned];

   axi_vram_rd_slave #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .ID_W      (ID_W),
      .MEM_WORDS (MEM_WORDS),
      .BASE_ADDR (BASE_ADDR),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .ARID      (ARID),
      .ARADDR    (ARADDR),
      .ARLEN     (ARLEN),
      .ARSIZE    (ARSIZE),
      .ARBURST   (ARBURST),
      .ARVALID   (ARVALID),
      .ARREADY   (ARREADY),
      .RID       (RID),
      .RDATA     (RDATA),
      .RRESP     (RRESP),
      .RLAST     (RLAST),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .MEM_WE    (MEM_WE),
      .MEM_WADDR (MEM_WADDR),
      .MEM_WDATA (MEM_WDATA)
   );

   // 100 MHz clock
   always #5 ACLK = ~ACLK;

   // Hard stop in case something waits forever despite the per-wait bounds.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge; all sampling and driving
   // happens at this point, well away from the edge itself.
   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic backdoorWrite(input int unsigned idx, input logic [31:0] data);
      MEM_WE    = 1'b1;
      MEM_WADDR = AW'(idx);
      MEM_WDATA = data;
      step();
      MEM_WE = 1'b0;
      if (idx < MEM_WORDS) modelMem[idx] = data;
   endtask

   // Expected response and data for one beat, straight from the address rules.
   function automatic void modelBeat(input logic [31:0] addr, input logic [2:0] size,
                                     input logic [1:0] burst, input int beat,
                                     output logic [1:0] resp, output logic [31:0] data);
      longint unsigned idx;
      resp = RESP_SLVERR;
      data = 32'h0;
      if (addr < BASE_ADDR || size != SIZE_4B || burst == BURST_WRAP || burst == 2'b11) return;
      idx = 64'((addr - BASE_ADDR) >> 2);
      if (burst == BURST_INCR) idx += 64'(beat);
      if (idx >= 64'(MEM_WORDS)) return;
      resp = RESP_OKAY;
      data = modelMem.exists(32'(idx)) ? modelMem[32'(idx)] : 32'hxxxx_xxxx;
   endfunction

   // Present one address and hold ARVALID until it is taken (bounded).
   task automatic applyStimulus(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, output int stalls);
      ARID    = id;
      ARADDR  = addr;
      ARLEN   = len;
      ARSIZE  = size;
      ARBURST = burst;
      ARVALID = 1'b1;
      stalls  = 0;
      while (!ARREADY && stalls < 200) begin
         step();
         stalls++;
      end
      checkOutput("ar_handshake", 64'(ARREADY), 64'd1);
      step();
      ARVALID = 1'b0;
   endtask

   // Collect the beats of the burst just accepted, checking each against the
   // model, checking hold stability on stalls, and optionally beat timing.
   // abortAfter >= 0 stops collecting once that beat has been taken.
   task automatic collectBurst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input bit randomReady, input bit checkTiming, input int abortAfter);
      int          beat    = 0;
      int          cyc     = 0;
      int          limit   = 20 * (int'(len) + 1) + 40;
      bit          holding = 1'b0;
      bit          aborted = 1'b0;
      logic [31:0] heldData = '0;
      logic [1:0]  heldResp = '0;
      logic        heldLast = 1'b0;
      logic [ID_W-1:0] heldId = '0;
      logic [1:0]  expResp;
      logic [31:0] expData;
      if (checkTiming) checkOutput("fetch_rvalid_low", 64'(RVALID), 64'd0);
      while (beat <= int'(len) && cyc < limit) begin
         RREADY = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (RVALID) begin
            if (holding) begin
               checkOutput("hold_rdata", 64'(RDATA), 64'(heldData));
               checkOutput("hold_rresp", 64'(RRESP), 64'(heldResp));
               checkOutput("hold_rlast", 64'(RLAST), 64'(heldLast));
               checkOutput("hold_rid",   64'(RID),   64'(heldId));
            end
            if (RREADY) begin
               modelBeat(addr, size, burst, beat, expResp, expData);
               checkOutput($sformatf("rdata_b%0d", beat), 64'(RDATA), 64'(expData));
               checkOutput($sformatf("rresp_b%0d", beat), 64'(RRESP), 64'(expResp));
               checkOutput($sformatf("rlast_b%0d", beat), 64'(RLAST), 64'(beat == int'(len)));
               checkOutput($sformatf("rid_b%0d", beat),   64'(RID),   64'(id));
               if (checkTiming) checkOutput($sformatf("beat_cycle_b%0d", beat), 64'(cyc), 64'(1 + 2 * beat));
               beat++;
               holding = 1'b0;
            end else begin
               holding  = 1'b1;
               heldData = RDATA;
               heldResp = RRESP;
               heldLast = RLAST;
               heldId   = RID;
            end
         end
         step();
         cyc++;
         if (abortAfter >= 0 && beat > abortAfter) begin
            aborted = 1'b1;
            break;
         end
      end
      RREADY = 1'b0;
      if (!aborted) begin
         if (beat <= int'(len)) checkOutput("burst_timeout_beats", 64'(beat), 64'(int'(len) + 1));
         else checkOutput("rvalid_drop_after_last", 64'(RVALID), 64'd0);
      end
   endtask

   task automatic readBurst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input bit randomReady, input bit checkTiming);
      int stalls;
      applyStimulus(id, addr, len, size, burst, stalls);
      collectBurst(id, addr, len, size, burst, randomReady, checkTiming, -1);
   endtask

   initial begin
      int          stalls;
      int          idx;
      logic [31:0] oldWord;
      logic [31:0] newWord;

      ARESET    = 1'b1;
      ARID      = '0;
      ARADDR    = '0;
      ARLEN     = '0;
      ARSIZE    = SIZE_4B;
      ARBURST   = BURST_INCR;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
      MEM_WE    = 1'b0;
      MEM_WADDR = '0;
      MEM_WDATA = '0;

      // Reset values
      repeat (3) step();
      checkOutput("reset_arready", 64'(ARREADY), 64'd0);
      checkOutput("reset_rvalid",  64'(RVALID),  64'd0);
      checkOutput("reset_rlast",   64'(RLAST),   64'd0);
      checkOutput("reset_rresp",   64'(RRESP),   64'd0);
      checkOutput("reset_rdata",   64'(RDATA),   64'd0);
      checkOutput("reset_rid",     64'(RID),     64'd0);
      ARESET = 1'b0;
      step();
`ifndef AXI_VRAM_ARREADY_RANDOM_EN
      checkOutput("idle_arready", 64'(ARREADY), 64'd1);
`endif

      // Preload: ramp in the first 16 words, random data around it and at the top
      for (int i = 0; i < 16; i++) backdoorWrite(i, 32'(i));
      for (int i = 16; i < 64; i++) backdoorWrite(i, $urandom & 32'h00FF_FFFF);
      for (int i = MEM_WORDS - 10; i < MEM_WORDS; i++) backdoorWrite(i, $urandom & 32'h00FF_FFFF);

      $display("[TB] scenario 1: 16-beat INCR, RREADY high");
      applyStimulus(1'b1, BASE_ADDR, 8'd15, SIZE_4B, BURST_INCR, stalls);
`ifndef AXI_VRAM_ARREADY_RANDOM_EN
      checkOutput("s1_ar_no_stall", 64'(stalls), 64'd0);
`endif
      collectBurst(1'b1, BASE_ADDR, 8'd15, SIZE_4B, BURST_INCR, 1'b0, 1'b1, -1);

      $display("[TB] scenario 2: same burst, random RREADY");
      readBurst(1'b0, BASE_ADDR, 8'd15, SIZE_4B, BURST_INCR, 1'b1, 1'b0);

      $display("[TB] scenario 3: INCR running off the end of memory");
      readBurst(1'b1, BASE_ADDR + 32'(4 * (MEM_WORDS - 2)), 8'd3, SIZE_4B, BURST_INCR, 1'b0, 1'b1);

      $display("[TB] scenario 4: FIXED, bad size, WRAP, reserved, below base, unaligned");
      readBurst(1'b0, BASE_ADDR + 32'd8, 8'd3, SIZE_4B, BURST_FIXED, 1'b0, 1'b1);
      readBurst(1'b1, BASE_ADDR, 8'd3, 3'b011, BURST_INCR, 1'b0, 1'b0);
      readBurst(1'b0, BASE_ADDR, 8'd2, SIZE_4B, BURST_WRAP, 1'b0, 1'b0);
      readBurst(1'b1, BASE_ADDR + 32'd4, 8'd1, SIZE_4B, 2'b11, 1'b0, 1'b0);
      readBurst(1'b0, BASE_ADDR - 32'd4, 8'd1, SIZE_4B, BURST_INCR, 1'b0, 1'b0);
      readBurst(1'b1, BASE_ADDR + 32'd23, 8'd1, SIZE_4B, BURST_INCR, 1'b1, 1'b0);

      $display("[TB] scenario 5: reset in the middle of a burst");
      applyStimulus(1'b1, BASE_ADDR, 8'd15, SIZE_4B, BURST_INCR, stalls);
      collectBurst(1'b1, BASE_ADDR, 8'd15, SIZE_4B, BURST_INCR, 1'b0, 1'b0, 5);
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      checkOutput("abort_rvalid", 64'(RVALID), 64'd0);
      checkOutput("abort_rlast",  64'(RLAST),  64'd0);
      idx = 0;
      step();
      while (!ARREADY && idx < 200) begin
         step();
         idx++;
      end
      checkOutput("abort_idle_arready", 64'(ARREADY), 64'd1);
`ifndef AXI_VRAM_ARREADY_RANDOM_EN
      checkOutput("abort_arready_delay", 64'(idx), 64'd0);
`endif
      readBurst(1'b0, BASE_ADDR + 32'd12, 8'd0, SIZE_4B, BURST_INCR, 1'b0, 1'b1);

      $display("[TB] read-first collision with a backdoor write");
      applyStimulus(1'b1, BASE_ADDR + 32'd28, 8'd0, SIZE_4B, BURST_INCR, stalls);
      oldWord   = modelMem[7];
      newWord   = ~oldWord & 32'h00FF_FFFF;
      MEM_WE    = 1'b1;
      MEM_WADDR = AW'(7);
      MEM_WDATA = newWord;
      RREADY    = 1'b1;
      step();
      MEM_WE = 1'b0;
      checkOutput("collide_rvalid", 64'(RVALID), 64'd1);
      checkOutput("collide_rdata",  64'(RDATA),  64'(oldWord));
      checkOutput("collide_rlast",  64'(RLAST),  64'd1);
      step();
      RREADY = 1'b0;
      modelMem[7] = newWord;
      readBurst(1'b0, BASE_ADDR + 32'd28, 8'd0, SIZE_4B, BURST_INCR, 1'b0, 1'b0);

      $display("[TB] random bursts");
      for (int n = 0; n < 12; n++) begin
         idx = int'($urandom_range(0, 56));
         readBurst(1'($urandom_range(0, 1)), BASE_ADDR + 32'(4 * idx), 8'($urandom_range(0, 7)),
                   SIZE_4B, 2'($urandom_range(0, 1)), 1'b1, 1'b0);
      end

`ifdef AXI_VRAM_ARREADY_RANDOM_EN
      $display("[TB] scenario 6: 100 bursts against the throttled ARREADY");
      begin
         int totalStalls = 0;
         for (int n = 0; n < 100; n++) begin
            logic [7:0]      len6   = 8'($urandom_range(0, 3));
            logic [1:0]      burst6 = 2'($urandom_range(0, 1));
            logic [ID_W-1:0] id6    = 1'($urandom_range(0, 1));
            logic [31:0]     addr6  = BASE_ADDR + 32'(4 * $urandom_range(0, 56));
            applyStimulus(id6, addr6, len6, SIZE_4B, burst6, stalls);
            totalStalls += stalls;
            collectBurst(id6, addr6, len6, SIZE_4B, burst6, 1'b0, 1'b0, -1);
         end
         checkOutput("throttle_seen", 64'(totalStalls > 0), 64'd1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
